bram_char_reader: RTL and testbench
===================================

Name: bram_char_reader

Overview:
- Read-side sequencer for the single-port character BRAM (2k x 8, synchronous read, one-cycle latency).
- On each start it fetches one MSG_LEN-character frame, optionally rotated by a scroll offset, from BRAM.
- It streams the characters to the LCD write path over a valid/ready handshake.
- A 2-entry skid buffer absorbs the BRAM read latency, so back-pressure never drops or duplicates a character.

Parameters:
- ADDR_W, 11, BRAM address width.
- MSG_LEN, 32, characters per frame (2 LCD lines x 16); power of two, 2..1024.
- LINE_LEN, 16, characters per LCD line; must divide MSG_LEN.
- BASE_ADDR, 0, BRAM address of message character 0.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to emit one frame; ignored while busy=1.
- scroll_en  in  1  sampled at frame end; 1 advances the scroll offset by one.
- addr  out  ADDR_W  BRAM read address.
- rdata  in  8  BRAM data; valid the cycle after the address edge.
- char  out  8  character to the LCD driver.
- char_valid  out  1  char holds a valid character.
- char_ready  in  1  LCD driver accepts char this cycle.
- line_end  out  1  qualifies char; 1 on the last character of each line.
- frame_done  out  1  one-cycle pulse after the last character is accepted.
- busy  out  1  frame in progress.

Behaviour:
- Reset values (reset low, asynchronous): addr=BASE_ADDR, char=0, char_valid=0, line_end=0, frame_done=0, busy=0, offset=0, idx=0. The buffer is emptied and the pending-read flag is cleared. Reset mid-frame aborts the frame; no frame_done is generated.
- Address generation: addr = BASE_ADDR + ((idx + offset) mod MSG_LEN). The modulo is a mask to log2(MSG_LEN) bits; the addition to BASE_ADDR is ADDR_W-bit and wraps.
- Read issue: one read per cycle when occupancy + pending < 2 and idx < MSG_LEN.
  - Issuing a read sets pending and increments idx.
  - On the next cycle, rdata and the tag {line_end = ((issued idx mod LINE_LEN) == LINE_LEN-1)} are written into the buffer and pending clears.
- Buffer: 2-entry FIFO; the head drives char, line_end and char_valid.
  - An entry pops on char_valid & char_ready.
  - A simultaneous write and pop in the same cycle is legal; occupancy is unchanged.
  - char and line_end stay stable while char_valid=1 and char_ready=0.
- FSM states:
  - IDLE: busy=0. start moves to FETCH; idx is cleared in the same cycle.
  - FETCH: issue reads as above. Move to DRAIN when idx reaches MSG_LEN with the last read issued.
  - DRAIN: no new reads. When the buffer is empty, pending=0, and the final character has been accepted: pulse frame_done for one cycle, apply the offset update, and return to IDLE.
- Latency: with char_ready held high, the first char_valid appears 2 cycles after the start cycle, then one character per cycle. frame_done asserts the cycle after the last acceptance.
- Offset update: if scroll_en=1 when frame_done is generated, offset = (offset+1) mod MSG_LEN; 31 wraps to 0. Otherwise offset is unchanged.
- start while busy=1 is ignored and is not queued. start in the same cycle as frame_done is also ignored.
- addr holds its last value when no read is issued. The BRAM is always enabled, so a repeated address is harmless.

Test Plan:
- Bench BRAM model mem[BASE_ADDR+i] = 0x41+i for i = 0..31. Pulse start with char_ready=1 -> 32 characters 0x41..0x60 on consecutive cycles; first char_valid 2 cycles after start; line_end on 0x50 and 0x60 only; frame_done one cycle after 0x60 is accepted; busy=0 afterwards.
- Same memory, scroll_en=1 across three frames -> frame 2 starts with 0x42 and wraps 0x60->0x41 after 31 characters; frame 3 starts with 0x43. At offset=31 the next frame starts 0x60 then 0x41.
- Random char_ready pattern (about 40% high), including a 20-cycle low stall mid-frame -> exact in-order 32-character sequence with no drops or duplicates; char stable while stalled; buffer occupancy never exceeds 2.
- Pulse start again at character 10 of a running frame -> ignored; exactly 32 characters and a single frame_done.
- Assert reset low at character 12, then release and pulse start -> all outputs at reset values during reset; the new frame begins at 0x41 (offset=0); no frame_done from the aborted frame.
- BASE_ADDR=0x7F0, MSG_LEN=32 -> addresses run 0x7F0..0x7FF and then wrap to 0x000..0x00F; the character order matches the bench memory contents.

Source files
------------

// File: rtl/bram_char_reader.sv
// -----------------------------------------------------------------------------
// bram_char_reader
//
// Read-side sequencer for the single-port character BRAM (synchronous read,
// one-cycle latency). Each accepted start fetches one MSG_LEN-character frame,
// rotated by a scroll offset, and streams it to the LCD write path over a
// valid/ready handshake. A 2-entry FIFO absorbs the BRAM read latency so that
// back-pressure never drops or duplicates a character.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle frame request (ignored while busy)
//   scroll_en   sampled on frame_done; 1 advances the scroll offset by one
//   addr        BRAM read address (captured by the BRAM on the rising edge)
//   rdata       BRAM read data, valid the cycle after the address edge
//   char        character to the LCD driver (FIFO head)
//   char_valid  char holds a valid character
//   char_ready  LCD driver accepts char this cycle
//   line_end    qualifies char: last character of an LCD line
//   frame_done  one-cycle pulse after the last character is accepted
//   busy        frame in progress
// -----------------------------------------------------------------------------
module bram_char_reader #(
  parameter int ADDR_W    = 11,
  parameter int MSG_LEN   = 32,
  parameter int LINE_LEN  = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              scroll_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        rdata,
  output logic [7:0]        char,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              line_end,
  output logic              frame_done,
  output logic              busy
);

  localparam int OFS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  // One extra bit so idx can hold MSG_LEN itself ("all reads issued").
  localparam int IDX_W = OFS_W + 1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  MSG_END   = IDX_W'(MSG_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0]  LINE_MOD  = IDX_W'(LINE_LEN);
  localparam logic [IDX_W-1:0]  LINE_LAST = IDX_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Frame position and scroll offset
  logic [IDX_W-1:0]  idx;
  logic [OFS_W-1:0]  offset;
  logic [OFS_W-1:0]  ofs_sum;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W-1:0] rd_addr;

  // Outstanding BRAM read and its line_end tag
  logic pending;
  logic pending_le;

  // 2-entry FIFO
  logic [7:0] fifo_data [2];
  logic       fifo_le   [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  // Control
  logic       pop;
  logic       issue;
  logic       clear_idx;
  logic       issue_le;
  logic [2:0] load;

  // ---------------------------------------------------------------------------
  // Address generation: the rotation wraps inside the frame (OFS_W-bit add),
  // the BRAM address add wraps at ADDR_W bits.
  // ---------------------------------------------------------------------------
  assign ofs_sum  = idx[OFS_W-1:0] + offset;
  assign rd_addr  = BASE + ADDR_W'(ofs_sum);
  assign issue_le = ((idx % LINE_MOD) == LINE_LAST);

  // The BRAM captures addr on the edge that ends the issuing cycle, so the new
  // address is presented combinationally while a read is issued; otherwise the
  // last issued address is held.
  assign addr = issue ? rd_addr : addr_hold;

  // ---------------------------------------------------------------------------
  // FIFO head drives the output side.
  // ---------------------------------------------------------------------------
  assign char_valid = (count != 2'd0);
  assign char       = fifo_data[rd_ptr];
  assign line_end   = char_valid & fifo_le[rd_ptr];
  assign pop        = char_valid & char_ready;

  // Occupancy once this cycle's pop has happened plus the read in flight. A new
  // read lands one cycle after issue, so it must still find a free slot; using
  // the post-pop occupancy keeps one character per cycle with char_ready high.
  assign load = {1'b0, count} + {2'b00, pending} - {2'b00, pop};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    clear_idx  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clear_idx  = 1'b1;
          state_next = FETCH;
        end
      end

      FETCH: begin
        if ((idx < MSG_END) && (load < 3'd2)) begin
          issue = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Buffer empty and nothing in flight: the last character has been
        // accepted on the previous edge.
        if ((count == 2'd0) && !pending) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame position, held address, scroll offset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      addr_hold <= BASE;
      offset    <= '0;
    end else begin
      if (clear_idx) begin
        idx <= '0;
      end else if (issue) begin
        idx <= idx + IDX_W'(1);
      end

      if (issue) begin
        addr_hold <= rd_addr;
      end

      // Power-of-two frame length: the OFS_W-bit add wraps MSG_LEN-1 to 0.
      if (frame_done && scroll_en) begin
        offset <= offset + OFS_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read in flight: rdata becomes valid the cycle after issue.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= 1'b0;
      pending_le <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_le <= issue_le;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO. Write and pop in the same cycle leave occupancy unchanged.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_le[i]   <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pending) begin
        fifo_data[wr_ptr] <= rdata;
        fifo_le[wr_ptr]   <= pending_le;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, pending} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_char_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_char_reader
//
// Two instances: dut_a at BASE_ADDR 0 and dut_b at BASE_ADDR 0x7F0 (address
// wrap). Each has its own BRAM model. The reference model is the frame rule
// itself: character i of a frame at offset o is mem[(BASE + (i+o) mod 32)
// mod 2048], line_end marks i mod 16 == 15, and the offset advances on
// frame_done when scroll_en is high. Inputs are driven and outputs sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_bram_char_reader;

  localparam int AW     = 11;
  localparam int ML     = 32;
  localparam int LL     = 16;
  localparam int BASE_A = 0;
  localparam int BASE_B = 'h7F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, start_a, scroll_a, ready_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    rdata_a, char_a;
  logic          valid_a, le_a, fd_a, busy_a;

  logic          reset_b, start_b, scroll_b, ready_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    rdata_b, char_b;
  logic          valid_b, le_b, fd_b, busy_b;

  logic [7:0] mem_a [0:2047];
  logic [7:0] mem_b [0:2047];

  int n_assert = 0;
  int n_fail   = 0;
  int off_model [2];

  bram_char_reader #(.ADDR_W(AW), .MSG_LEN(ML), .LINE_LEN(LL), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .scroll_en(scroll_a),
    .addr(addr_a), .rdata(rdata_a), .char(char_a), .char_valid(valid_a),
    .char_ready(ready_a), .line_end(le_a), .frame_done(fd_a), .busy(busy_a)
  );

  bram_char_reader #(.ADDR_W(AW), .MSG_LEN(ML), .LINE_LEN(LL), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .scroll_en(scroll_b),
    .addr(addr_b), .rdata(rdata_b), .char(char_b), .char_valid(valid_b),
    .char_ready(ready_b), .line_end(le_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Synchronous-read BRAM models, one-cycle latency
  always @(posedge clk) rdata_a <= mem_a[addr_a];
  always @(posedge clk) rdata_b <= mem_b[addr_b];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input bit sel, input int i, input int off);
    int a;
    a = ((sel ? BASE_B : BASE_A) + ((i + off) % ML)) % 2048;
    return sel ? mem_b[a] : mem_a[a];
  endfunction

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic drive_ready(input bit sel, input logic v);
    if (sel) ready_b = v; else ready_a = v;
  endtask

  task automatic drive_scroll(input bit sel, input logic v);
    if (sel) scroll_b = v; else scroll_a = v;
  endtask

  task automatic drive_reset(input bit sel, input logic v);
    if (sel) reset_b = v; else reset_a = v;
  endtask

  // One frame: start pulse, random/held ready, optional stall, optional
  // re-start while busy, optional reset abort, optional start on frame_done.
  task automatic run_frame(input bit sel, input int pct, input bit scroll,
                           input int stall_at, input int restart_at,
                           input int abort_at, input bit start_on_done);
    int acc = 0;
    int first_v = -1;
    int last_acc = -1;
    int stall_left = 0;
    int tail_bad = 0;
    int off;
    bit stalled = 0, restarted = 0, done = 0, aborted = 0;
    bit prev_hold = 0;
    logic [7:0] prev_c = '0;
    logic prev_le = 1'b0;
    logic rdy, v, le, fd, bz;
    logic [7:0] c;

    off = off_model[sel];
    @(negedge clk);
    drive_start(sel, 1'b1);
    drive_scroll(sel, scroll);
    drive_ready(sel, 1'b0);

    for (int cyc = 1; cyc <= 600 && !done && !aborted; cyc++) begin
      @(negedge clk);
      drive_start(sel, 1'b0);
      if (stall_at >= 0 && !stalled && acc == stall_at) begin
        stall_left = 20;
        stalled    = 1;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < pct);
      end
      drive_ready(sel, rdy);

      v  = sel ? valid_b : valid_a;
      c  = sel ? char_b  : char_a;
      le = sel ? le_b    : le_a;
      fd = sel ? fd_b    : fd_a;
      bz = sel ? busy_b  : busy_a;

      if (cyc == 1) chk("busy_after_start", bz, 1);
      if (prev_hold) begin
        chk("stall_valid", v, 1);
        chk("stall_char", c, prev_c);
        chk("stall_line_end", le, prev_le);
      end

      if (fd) begin
        done = 1;
        chk("done_char_count", acc, ML);
        chk("done_timing", cyc, last_acc + 1);
        if (scroll) off_model[sel] = (off_model[sel] + 1) % ML;
        if (start_on_done) drive_start(sel, 1'b1);
      end else begin
        if (v && first_v < 0) first_v = cyc;
        if (v && rdy) begin
          if (acc >= ML) begin
            chk("extra_char", acc, ML - 1);
          end else begin
            chk("char", c, exp_char(sel, acc, off));
            chk("line_end", le, ((acc % LL) == LL - 1));
          end
          acc++;
          last_acc = cyc;
        end
        prev_hold = v && !rdy;
        prev_c    = c;
        prev_le   = le;

        if (restart_at >= 0 && !restarted && acc == restart_at) begin
          restarted = 1;
          drive_start(sel, 1'b1);
        end

        if (abort_at >= 0 && acc == abort_at) begin
          aborted = 1;
          drive_reset(sel, 1'b0);
          #1;
          chk("rst_addr", sel ? addr_b : addr_a, sel ? BASE_B : BASE_A);
          chk("rst_char", sel ? char_b : char_a, 0);
          chk("rst_valid", sel ? valid_b : valid_a, 0);
          chk("rst_line_end", sel ? le_b : le_a, 0);
          chk("rst_frame_done", sel ? fd_b : fd_a, 0);
          chk("rst_busy", sel ? busy_b : busy_a, 0);
          off_model[sel] = 0;
          repeat (2) @(negedge clk);
          chk("rst_held_valid", sel ? valid_b : valid_a, 0);
          drive_reset(sel, 1'b1);
        end
      end
    end

    chk("frame_finished", (done || aborted), 1);

    if (pct >= 100 && stall_at < 0 && done) begin
      chk("first_valid_latency", first_v, 3);
      chk("back_to_back", last_acc - first_v, ML - 1);
    end

    // Quiet tail: no further characters, frame_done or busy
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      drive_start(sel, 1'b0);
      drive_ready(sel, 1'b1);
      if (sel ? (valid_b || fd_b || busy_b) : (valid_a || fd_a || busy_a)) tail_bad++;
    end
    chk("tail_quiet", tail_bad, 0);
    $display("frame sel=%0d off=%0d chars=%0d done=%0d aborted=%0d", sel, off, acc, done, aborted);
  endtask

  initial begin
    reset_a = 1'b0; start_a = 1'b0; scroll_a = 1'b0; ready_a = 1'b0;
    reset_b = 1'b0; start_b = 1'b0; scroll_b = 1'b0; ready_b = 1'b0;
    off_model[0] = 0;
    off_model[1] = 0;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < ML; i++) mem_a[BASE_A + i] = 8'(8'h41 + i);

    repeat (3) @(negedge clk);
    chk("reset_addr_a", addr_a, BASE_A);
    chk("reset_addr_b", addr_b, BASE_B);
    chk("reset_char", char_a, 0);
    chk("reset_valid", valid_a, 0);
    chk("reset_line_end", le_a, 0);
    chk("reset_frame_done", fd_a, 0);
    chk("reset_busy", busy_a, 0);
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Full-rate frames with scrolling, through the offset wrap 31 -> 0
    run_frame(0, 100, 1, -1, -1, -1, 0);
    run_frame(0, 100, 1, -1, -1, -1, 0);
    run_frame(0, 100, 1, -1, -1, -1, 0);
    while (off_model[0] != ML - 1) run_frame(0, 100, 1, -1, -1, -1, 0);
    run_frame(0, 100, 1, -1, -1, -1, 0);
    run_frame(0, 100, 0, -1, -1, -1, 0);

    // Random back-pressure with a 20-cycle stall mid-frame
    run_frame(0, 40, 1, 15, -1, -1, 0);

    // start while busy and start during frame_done are both ignored
    run_frame(0, 70, 0, -1, 10, -1, 1);

    // Reset abort at character 12, then a fresh frame from offset 0
    run_frame(0, 60, 0, -1, -1, 12, 0);
    run_frame(0, 100, 0, -1, -1, -1, 0);

    // BASE_ADDR near the top of the BRAM: addresses wrap past 0x7FF
    run_frame(1, 100, 1, -1, -1, -1, 0);
    chk("addr_after_wrap", addr_b, 'h00F);
    run_frame(1, 50, 0, 5, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
